// File: rtl/fp_register_read_stage_receiver_pkg.sv
// Shared pipeline types for the FP issue -> FP register-read boundary.
// Also holds the active-list age compare that the recovery logic reuses.
package fp_register_read_stage_receiver_pkg;

  localparam int unsigned FP_ISSUE_WIDTH = 2;
  localparam int unsigned PAYLOAD_WIDTH  = 96;
  localparam int unsigned AL_INDEX_WIDTH = 6;

  typedef struct packed {
    logic                      wrap;
    logic [AL_INDEX_WIDTH-1:0] index;
  } ActiveListPtr;

  typedef struct packed {
    logic                     valid;
    logic [PAYLOAD_WIDTH-1:0] payload;
    ActiveListPtr             al_ptr;
  } FPRegisterReadStageRegPath;

  // True when p is the same age as r or younger. Only meaningful while the two
  // pointers are less than one full lap apart, which the active list guarantees.
  function automatic logic IsYoungerOrEqual(ActiveListPtr p, ActiveListPtr r);
    if (p.wrap == r.wrap) begin
      return p.index >= r.index;
    end
    return p.index < r.index;
  endfunction

endpackage

// File: rtl/fp_rr_lane_reg.sv
// One lane of the FP register-read pipeline register: load on no-stall, hold on
// stall, and drop valid whenever the resident op is killed by a flush or recovery.
module fp_rr_lane_reg
  import fp_register_read_stage_receiver_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      in_valid,
  input  logic [PAYLOAD_WIDTH-1:0]  in_payload,
  input  ActiveListPtr              in_al_ptr,
  input  logic                      recover,
  input  ActiveListPtr              recover_al_ptr,
  input  logic                      flush_all,
  output FPRegisterReadStageRegPath out_reg
);

  FPRegisterReadStageRegPath reg_d, reg_q;
  logic                      kill;

  always_comb begin
    reg_d = reg_q;
    if (!stall) begin
      reg_d.valid   = in_valid;
      reg_d.payload = in_payload;
      reg_d.al_ptr  = in_al_ptr;
    end
    // Kill is judged on whichever op will occupy the lane: incoming or held.
    kill = flush_all | (recover & IsYoungerOrEqual(reg_d.al_ptr, recover_al_ptr));
    if (kill) begin
      reg_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_q <= '0;
    end else begin
      reg_q <= reg_d;
    end
  end

  assign out_reg = reg_q;

endmodule

// File: rtl/fp_register_read_stage_receiver.sv
// Receiving side of the FP issue -> register-read pipeline register: per-lane
// hold/kill registers, popcount of surviving lanes and a saturating delivered-op counter.
module fp_register_read_stage_receiver #(
  parameter int unsigned FP_ISSUE_WIDTH   = 2,
  parameter int unsigned PAYLOAD_WIDTH    = 96,
  parameter int unsigned AL_INDEX_WIDTH   = 6,
  parameter int unsigned PERF_COUNT_WIDTH = 16
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             stall,
  input  logic [FP_ISSUE_WIDTH-1:0]                        in_valid,
  input  logic [FP_ISSUE_WIDTH-1:0][PAYLOAD_WIDTH-1:0]     in_payload,
  input  logic [FP_ISSUE_WIDTH-1:0][AL_INDEX_WIDTH:0]      in_al_ptr,
  input  logic                                             recover,
  input  logic [AL_INDEX_WIDTH:0]                          recover_al_ptr,
  input  logic                                             flush_all,
  output logic [FP_ISSUE_WIDTH-1:0]                        out_valid,
  output logic [FP_ISSUE_WIDTH-1:0][PAYLOAD_WIDTH-1:0]     out_payload,
  output logic [FP_ISSUE_WIDTH-1:0][AL_INDEX_WIDTH:0]      out_al_ptr,
  output logic [$clog2(FP_ISSUE_WIDTH+1)-1:0]              out_valid_count,
  output logic [PERF_COUNT_WIDTH-1:0]                      perf_delivered
);

  localparam int unsigned CountWidth = $clog2(FP_ISSUE_WIDTH + 1);
  localparam logic [PERF_COUNT_WIDTH-1:0] PerfMax = '1;

  fp_register_read_stage_receiver_pkg::FPRegisterReadStageRegPath lane_q [FP_ISSUE_WIDTH];

  for (genvar i = 0; i < FP_ISSUE_WIDTH; i++) begin : g_lane
    fp_rr_lane_reg u_lane (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .in_valid       (in_valid[i]),
      .in_payload     (in_payload[i]),
      .in_al_ptr      (in_al_ptr[i]),
      .recover        (recover),
      .recover_al_ptr (recover_al_ptr),
      .flush_all      (flush_all),
      .out_reg        (lane_q[i])
    );

    assign out_valid[i]   = lane_q[i].valid;
    assign out_payload[i] = lane_q[i].payload;
    assign out_al_ptr[i]  = lane_q[i].al_ptr;
  end

  always_comb begin
    out_valid_count = '0;
    for (int i = 0; i < FP_ISSUE_WIDTH; i++) begin
      out_valid_count = out_valid_count + CountWidth'(out_valid[i]);
    end
  end

  // One extra bit catches the carry so the counter can clamp instead of wrapping.
  logic [PERF_COUNT_WIDTH:0]   perf_sum;
  logic [PERF_COUNT_WIDTH-1:0] perf_d, perf_q;

  assign perf_sum = {1'b0, perf_q} + (PERF_COUNT_WIDTH + 1)'(out_valid_count);

  always_comb begin
    perf_d = perf_q;
    if (!stall) begin
      perf_d = perf_sum[PERF_COUNT_WIDTH] ? PerfMax : perf_sum[PERF_COUNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_delivered = perf_q;

endmodule

// File: tb/tb_fp_register_read_stage_receiver.sv
// Bench for fp_register_read_stage_receiver: directed vector table, hand-written reset and
// saturation sequences, and random traffic against a modular-arithmetic reference model.
module tb_fp_register_read_stage_receiver;

  localparam int W  = 2;
  localparam int PW = 96;
  localparam int AW = 6;
  localparam int CW = 16;
  localparam int PtrMod = 2 ** (AW + 1);
  localparam int PerfMaxInt = 2 ** CW - 1;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     stall = 1'b0;
  logic                     recover = 1'b0;
  logic                     flush_all = 1'b0;
  logic [W-1:0]             in_valid = '0;
  logic [W-1:0][PW-1:0]     in_payload = '0;
  logic [W-1:0][AW:0]       in_al_ptr = '0;
  logic [AW:0]              recover_al_ptr = '0;
  logic [W-1:0]             out_valid;
  logic [W-1:0][PW-1:0]     out_payload;
  logic [W-1:0][AW:0]       out_al_ptr;
  logic [$clog2(W+1)-1:0]   out_valid_count;
  logic [CW-1:0]            perf_delivered;

  fp_register_read_stage_receiver #(
    .FP_ISSUE_WIDTH   (W),
    .PAYLOAD_WIDTH    (PW),
    .AL_INDEX_WIDTH   (AW),
    .PERF_COUNT_WIDTH (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .in_valid        (in_valid),
    .in_payload      (in_payload),
    .in_al_ptr       (in_al_ptr),
    .recover         (recover),
    .recover_al_ptr  (recover_al_ptr),
    .flush_all       (flush_all),
    .out_valid       (out_valid),
    .out_payload     (out_payload),
    .out_al_ptr      (out_al_ptr),
    .out_valid_count (out_valid_count),
    .perf_delivered  (perf_delivered)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit             m_val [W];
  logic [PW-1:0]  m_pay [W];
  logic [AW:0]    m_ptr [W];
  int             m_perf;

  // Age by modular distance: p is younger-or-equal iff (p - r) mod 2^(AW+1) < 2^AW.
  function automatic bit younger_eq(logic [AW:0] p, logic [AW:0] r);
    int d;
    d = (int'(p) - int'(r) + PtrMod) % PtrMod;
    return d < (PtrMod / 2);
  endfunction

  function automatic bit killed(logic [AW:0] p);
    return flush_all || (recover && younger_eq(p, recover_al_ptr));
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < W; i++) begin
      m_val[i] = 1'b0;
      m_pay[i] = '0;
      m_ptr[i] = '0;
    end
    m_perf = 0;
  endtask

  task automatic check_model(string tag);
    logic [W-1:0] ev;
    int cnt;
    cnt = 0;
    for (int i = 0; i < W; i++) begin
      ev[i] = m_val[i];
      cnt += int'(m_val[i]);
      check($sformatf("%s_payload%0d", tag, i), 128'(out_payload[i]), 128'(m_pay[i]));
      check($sformatf("%s_alptr%0d", tag, i), 128'(out_al_ptr[i]), 128'(m_ptr[i]));
    end
    check($sformatf("%s_valid", tag), 128'(out_valid), 128'(ev));
    check($sformatf("%s_count", tag), 128'(out_valid_count), 128'(cnt));
    check($sformatf("%s_perf", tag), 128'(perf_delivered), 128'(m_perf));
  endtask

  // Advance the model by one clock using the inputs currently driven, then clock the DUT.
  task automatic tick(bit do_check, string tag);
    int cnt;
    cnt = 0;
    for (int i = 0; i < W; i++) cnt += int'(m_val[i]);
    if (!stall) begin
      m_perf += cnt;
      if (m_perf > PerfMaxInt) m_perf = PerfMaxInt;
    end
    for (int i = 0; i < W; i++) begin
      if (!stall) begin
        m_val[i] = in_valid[i];
        m_pay[i] = in_payload[i];
        m_ptr[i] = in_al_ptr[i];
      end
      if (killed(m_ptr[i])) m_val[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    if (do_check) check_model(tag);
  endtask

  typedef struct {
    logic          st;
    logic [1:0]    iv;
    logic [PW-1:0] p0, p1;
    logic [AW:0]   a0, a1;
    logic          rec;
    logic [AW:0]   ra;
    logic          fl;
    logic [1:0]    ev;
    logic [PW-1:0] e0, e1;
  } vec_t;

  vec_t vecs [9];

  function automatic vec_t mk(logic st, logic [1:0] iv, logic [PW-1:0] p0, logic [PW-1:0] p1,
                              logic [AW:0] a0, logic [AW:0] a1, logic rec, logic [AW:0] ra,
                              logic fl, logic [1:0] ev, logic [PW-1:0] e0, logic [PW-1:0] e1);
    vec_t v;
    v.st = st; v.iv = iv; v.p0 = p0; v.p1 = p1; v.a0 = a0; v.a1 = a1;
    v.rec = rec; v.ra = ra; v.fl = fl; v.ev = ev; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int guard;

    //                st    iv     p0     p1     a0      a1     rec   ra     fl    ev     e0     e1
    vecs[0] = mk(1'b0, 2'b11, 96'hA, 96'hB, 7'h05, 7'h09, 1'b0, 7'h00, 1'b0, 2'b11, 96'hA, 96'hB);
    vecs[1] = mk(1'b1, 2'b11, 96'hC, 96'hD, 7'h05, 7'h09, 1'b0, 7'h00, 1'b0, 2'b11, 96'hA, 96'hB);
    vecs[2] = mk(1'b1, 2'b11, 96'hC, 96'hD, 7'h05, 7'h09, 1'b0, 7'h00, 1'b0, 2'b11, 96'hA, 96'hB);
    vecs[3] = mk(1'b1, 2'b11, 96'hC, 96'hD, 7'h05, 7'h09, 1'b0, 7'h00, 1'b0, 2'b11, 96'hA, 96'hB);
    vecs[4] = mk(1'b0, 2'b11, 96'hC, 96'hD, 7'h05, 7'h09, 1'b0, 7'h00, 1'b0, 2'b11, 96'hC, 96'hD);
    // Held {0,5},{0,9} vs recover {0,7}: lane0 older survives, lane1 dies.
    vecs[5] = mk(1'b1, 2'b11, 96'h7, 96'h8, 7'h11, 7'h12, 1'b1, 7'h07, 1'b0, 2'b01, 96'hC, 96'hD);
    // Wrap: recover {1,0}; {0,63} kept, {1,2} killed.
    vecs[6] = mk(1'b0, 2'b11, 96'hE, 96'hF, 7'h3F, 7'h42, 1'b1, 7'h40, 1'b0, 2'b01, 96'hE, 96'hF);
    vecs[7] = mk(1'b0, 2'b11, 96'h1, 96'h2, 7'h3F, 7'h42, 1'b1, 7'h40, 1'b1, 2'b00, 96'h1, 96'h2);
    vecs[8] = mk(1'b0, 2'b11, 96'h3, 96'h4, 7'h00, 7'h01, 1'b0, 7'h00, 1'b0, 2'b11, 96'h3, 96'h4);

    // Power-on reset, then some traffic, then async reset mid-stream.
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("por");
    rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      in_valid = 2'b11;
      in_payload[0] = {$urandom, $urandom, $urandom};
      in_payload[1] = {$urandom, $urandom, $urandom};
      in_al_ptr[0] = 7'(n);
      in_al_ptr[1] = 7'(n + 1);
      tick(1'b1, "pre");
    end
    #2;
    rst = 1'b0;
    #1;
    check("rst_async_valid", 128'(out_valid), 128'(0));
    check("rst_async_payload", 128'(out_payload), 128'(0));
    check("rst_async_alptr", 128'(out_al_ptr), 128'(0));
    check("rst_async_perf", 128'(perf_delivered), 128'(0));
    model_reset();
    in_valid = 2'b11;
    in_payload[0] = 96'h11;
    in_payload[1] = 96'h22;
    @(posedge clk);
    #1;
    check("rst_held_valid", 128'(out_valid), 128'(0));
    rst = 1'b1;
    tick(1'b1, "rel");
    check("rel_valid", 128'(out_valid), 128'(2'b11));
    check("rel_count", 128'(out_valid_count), 128'(2));

    // Directed vector table
    for (int k = 0; k < 9; k++) begin
      stall = vecs[k].st;
      in_valid = vecs[k].iv;
      in_payload[0] = vecs[k].p0;
      in_payload[1] = vecs[k].p1;
      in_al_ptr[0] = vecs[k].a0;
      in_al_ptr[1] = vecs[k].a1;
      recover = vecs[k].rec;
      recover_al_ptr = vecs[k].ra;
      flush_all = vecs[k].fl;
      tick(1'b1, $sformatf("vec%0d", k));
      check($sformatf("vec%0d_tbl_valid", k), 128'(out_valid), 128'(vecs[k].ev));
      check($sformatf("vec%0d_tbl_pay0", k), 128'(out_payload[0]), 128'(vecs[k].e0));
      check($sformatf("vec%0d_tbl_pay1", k), 128'(out_payload[1]), 128'(vecs[k].e1));
    end

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      stall = ($urandom % 10) < 3;
      in_valid = 2'($urandom);
      in_payload[0] = {$urandom, $urandom, $urandom};
      in_payload[1] = {$urandom, $urandom, $urandom};
      in_al_ptr[0] = 7'($urandom);
      in_al_ptr[1] = 7'($urandom);
      recover = ($urandom % 5) == 0;
      recover_al_ptr = 7'($urandom);
      flush_all = ($urandom % 20) == 0;
      tick(1'b1, "rnd");
    end

    // Counter saturation: restart from zero and stream two ops per cycle.
    stall = 1'b0;
    recover = 1'b0;
    flush_all = 1'b0;
    in_valid = 2'b11;
    in_al_ptr = '0;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    rst = 1'b1;
    guard = 0;
    while (m_perf != PerfMaxInt - 1 && guard < 40000) begin
      tick(1'b0, "fill");
      guard++;
    end
    check("sat_fill_reached", 128'(m_perf), 128'(PerfMaxInt - 1));
    check("sat_preload", 128'(perf_delivered), 128'(16'hFFFE));
    tick(1'b1, "sat1");
    check("sat_first", 128'(perf_delivered), 128'(16'hFFFF));
    tick(1'b1, "sat2");
    check("sat_hold", 128'(perf_delivered), 128'(16'hFFFF));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
